// File: rtl/spi_iomem_bridge_pkg.sv
// spi_iomem_bridge_pkg: command codes, frame states and defaults shared by the SPI-to-iomem bridge
package spi_iomem_bridge_pkg;
    localparam logic [7:0]  CMD_WRITE       = 8'h02;
    localparam logic [7:0]  CMD_READ        = 8'h03;
    localparam logic [7:0]  CMD_STATUS      = 8'h05;
    localparam logic [31:0] ERR_PATTERN_DEF = 32'hDEAD_BEEF;
    typedef enum logic [3:0] {IDLE, CMD, ADDR, WDATA, BUS, DUMMY, RDATA, STAT, DRAIN} state_t;
endpackage

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: synchronizes the SPI pins and shifts bytes in on SCK rise / out on SCK fall
// Ports: spi_sck/spi_csb/spi_mosi raw pins; tx_byte is the next byte to send; spi_miso data out;
//        csb is the synchronized chip select; byte_done pulses with rx_byte holding the full byte.
module spi_slave_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_csb,
    input  logic       spi_mosi,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic       csb,
    output logic       byte_done,
    output logic [7:0] rx_byte
);
    logic [2:0] sck_q;
    logic [1:0] csb_q;
    logic [1:0] mosi_q;
    logic [6:0] rx_sr;
    logic [6:0] tx_sr;
    logic [2:0] bit_cnt;
    logic       started;
    logic       rise;
    logic       fall;

    assign csb       = csb_q[1];
    assign rise      = sck_q[1] & ~sck_q[2];
    assign fall      = ~sck_q[1] & sck_q[2];
    assign byte_done = rise & ~csb & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_q[1]};

    // A fall with bit_cnt wrapped to 0 ends a byte, so the next byte is loaded there.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q    <= '0;
            csb_q    <= '1;
            mosi_q   <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            started  <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            csb_q  <= {csb_q[0], spi_csb};
            mosi_q <= {mosi_q[0], spi_mosi};
            if (csb) begin
                bit_cnt  <= '0;
                started  <= 1'b0;
                tx_sr    <= '0;
                spi_miso <= 1'b0;
            end else if (rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                started <= 1'b1;
            end else if (fall) begin
                {spi_miso, tx_sr} <= (bit_cnt == 3'd0 && started) ? tx_byte : {tx_sr, 1'b0};
            end
        end
    end
endmodule

// File: rtl/spi_iomem_bridge.sv
// spi_iomem_bridge: SPI-slave debug bridge issuing 32-bit iomem read/write cycles
// Ports: spi_* host pins (mode 0, async); iomem_* initiator bus; busy is high while a bus cycle is out.
module spi_iomem_bridge import spi_iomem_bridge_pkg::*; #(
    parameter int          TIMEOUT_CYCLES = 48,
    parameter logic [31:0] ERR_PATTERN    = ERR_PATTERN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_csb,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        st, nx;
    logic          csb, bd, wr, pend, err, last, req, go, tmo;
    logic [7:0]    rx, tx;
    logic [1:0]    bcnt;
    logic [31:0]   a_sh, d_sh, a_nx, d_nx, rd_data;
    logic [TW-1:0] tcnt;

    spi_slave_shifter u_shift (
        .clk       (clk),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_csb   (spi_csb),
        .spi_mosi  (spi_mosi),
        .tx_byte   (tx),
        .spi_miso  (spi_miso),
        .csb       (csb),
        .byte_done (bd),
        .rx_byte   (rx)
    );

    assign spi_miso_oe = ~csb;
    assign busy        = iomem_valid;
    assign last        = bd & (bcnt == 2'd3);
    // Reads launch at the end of the address so data is back before the dummy byte ends.
    assign req  = last & (((st == ADDR) & ~wr) | (st == WDATA));
    assign go   = req | pend;
    assign tmo  = iomem_valid & ~iomem_ready & (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign a_nx = (bd && st == ADDR) ? {a_sh[23:0], rx} : a_sh;
    assign d_nx = (bd && st == WDATA) ? {d_sh[23:0], rx} : d_sh;
    assign tx   = (st == STAT) ? {6'b0, err, busy} : (st == RDATA) ? rd_data[{~bcnt, 3'b000} +: 8] : 8'h00;

    always_comb begin
        nx = st;
        if (csb) begin
            nx = IDLE;
        end else begin
            case (st)
                IDLE:    nx = CMD;
                CMD:     if (bd) nx = (rx == CMD_WRITE || rx == CMD_READ) ? ADDR : (rx == CMD_STATUS) ? STAT : DRAIN;
                ADDR:    if (last) nx = wr ? WDATA : DUMMY;
                WDATA:   if (last) nx = BUS;
                DUMMY:   if (bd) nx = RDATA;
                RDATA:   if (last) nx = DRAIN;
                STAT:    if (bd) nx = DRAIN;
                default: nx = st;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= IDLE;
            bcnt <= '0;
            wr   <= 1'b0;
            a_sh <= '0;
            d_sh <= '0;
        end else begin
            st   <= nx;
            bcnt <= (nx != st) ? 2'd0 : bcnt + {1'b0, bd};
            a_sh <= a_nx;
            d_sh <= d_nx;
            if (bd && st == CMD) wr <= (rx == CMD_WRITE);
        end
    end

    // A request arriving while a cycle is out is held in pend; valid is never withdrawn early.
    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_valid <= 1'b0;
            iomem_wstrb <= '0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            rd_data     <= '0;
            tcnt        <= '0;
            pend        <= 1'b0;
            err         <= 1'b0;
        end else begin
            pend <= go & iomem_valid;
            err  <= tmo | (err & ~(bd && st == STAT));
            if (iomem_valid) begin
                tcnt <= tcnt + TW'(1);
                if (iomem_ready | tmo) begin
                    iomem_valid <= 1'b0;
                    rd_data     <= iomem_ready ? iomem_rdata : ERR_PATTERN;
                end
            end else if (go) begin
                iomem_valid <= 1'b1;
                iomem_addr  <= a_nx;
                iomem_wdata <= d_nx;
                iomem_wstrb <= wr ? 4'hF : 4'h0;
                tcnt        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_iomem_bridge.sv
// tb_spi_iomem_bridge: directed SPI frames with scoreboarded bus cycles and MISO bytes
module tb_spi_iomem_bridge;
    localparam int HALF = 6;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          len;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset, spi_sck, spi_csb, spi_mosi, spi_miso, spi_miso_oe;
    logic        iomem_valid, iomem_ready, busy;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

    bus_t        bus_q[$];
    logic [7:0]  exp_q[$], got_q[$], txq[$];
    int          checks = 0, errors = 0;
    int          resp_lat = 0, wc = 0, len = 0;
    logic [31:0] resp_data = 32'h0;
    bus_t        cur;
    logic        pv = 1'b0, unst = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [7:0]  g;

    spi_iomem_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_csb     (spi_csb),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic bus_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int l);
        bus_q.push_back('{a, d, s, l});
    endtask

    task automatic xfer(input logic [7:0] t, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = t[i];
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b1;
            r[i] = spi_miso;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input int first_out);
        logic [7:0] r;
        spi_csb = 1'b0;
        repeat (8) @(negedge clk);
        check("miso_oe_active", {31'b0, spi_miso_oe}, 1);
        foreach (txq[b]) begin
            xfer(txq[b], r);
            if (b >= first_out) got_q.push_back(r);
        end
        repeat (8) @(negedge clk);
        spi_csb = 1'b1;
        repeat (4) @(negedge clk);
        check("miso_oe_idle", {31'b0, spi_miso_oe}, 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, {31'b0, iomem_valid}, 0);
        check({tag, "_wstrb"}, {28'b0, iomem_wstrb}, 0);
        check({tag, "_addr"}, iomem_addr, 0);
        check({tag, "_wdata"}, iomem_wdata, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_miso"}, {31'b0, spi_miso}, 0);
        check({tag, "_miso_oe"}, {31'b0, spi_miso_oe}, 0);
    endtask

    // Responder: ready pulses for one cycle resp_lat cycles after valid is seen.
    initial begin
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (iomem_ready) begin
                iomem_ready = 1'b0;
            end else if (iomem_valid) begin
                if (wc == resp_lat) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = resp_data;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Bus monitor: checks each cycle's fields at issue, stability, duration and busy tracking.
    initial begin
        cur = '{32'h0, 32'h0, 4'h0, 0};
        forever begin
            @(negedge clk);
            if (iomem_valid && !pv) begin
                check("busy_at_issue", {31'b0, busy}, 1);
                s_addr  = iomem_addr;
                s_wdata = iomem_wdata;
                s_wstrb = iomem_wstrb;
                len     = 0;
                unst    = 1'b0;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus_cycle: got addr %h wstrb %h expected none", iomem_addr, iomem_wstrb);
                    cur = '{32'h0, 32'h0, 4'h0, 0};
                end else begin
                    cur = bus_q.pop_front();
                    check("bus_addr", iomem_addr, cur.addr);
                    check("bus_wstrb", {28'b0, iomem_wstrb}, {28'b0, cur.wstrb});
                    if (cur.wstrb == 4'hF) check("bus_wdata", iomem_wdata, cur.wdata);
                end
            end
            if (iomem_valid) begin
                len++;
                if (iomem_addr !== s_addr || iomem_wdata !== s_wdata || iomem_wstrb !== s_wstrb) unst = 1'b1;
            end
            if (!iomem_valid && pv) begin
                check("busy_at_end", {31'b0, busy}, 0);
                if (cur.len != 0) begin
                    check("valid_cycles", len, cur.len);
                    check("bus_stable", {31'b0, unst}, 0);
                end
            end
            pv = iomem_valid;
        end
    end

    // MISO monitor: compares every byte the host captured against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_extra: got %h expected none", g);
                end else begin
                    check("miso_byte", {24'b0, g}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_csb  = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        resp_lat = 0;
        bus_exp(32'h0300_0000, 32'h0000_00A5, 4'hF, 1);
        txq = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        frame(99);

        resp_lat  = 3;
        resp_data = 32'h1234_5678;
        bus_exp(32'h0300_0000, 32'h0, 4'h0, 4);
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        txq = '{8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(6);

        resp_lat = 1000;
        bus_exp(32'h0300_0004, 32'h0, 4'h0, 48);
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        txq = '{8'h03, 8'h03, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(6);

        exp_q.push_back(8'h02);
        txq = '{8'h05, 8'h00};
        frame(1);
        exp_q.push_back(8'h00);
        txq = '{8'h05, 8'h00};
        frame(1);

        txq = '{8'h03, 8'h03, 8'h00};
        frame(99);

        resp_lat = 2;
        bus_exp(32'h1000_0004, 32'h1122_3344, 4'hF, 3);
        txq = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        frame(99);

        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txq = '{8'h9F, 8'h01, 8'h02, 8'h03, 8'h04};
        frame(0);

        resp_lat = 1000;
        bus_exp(32'h0300_0008, 32'h0, 4'h0, 0);
        txq = '{8'h03, 8'h03, 8'h00, 8'h00, 8'h08};
        frame(99);
        check("valid_before_reset", {31'b0, iomem_valid}, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        resp_lat  = 1;
        resp_data = 32'hCAFE_F00D;
        bus_exp(32'h0000_0010, 32'h0, 4'h0, 2);
        exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        txq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txq[0] = 8'h03;
        frame(6);

        repeat (20) @(negedge clk);
        check("bus_queue_drained", bus_q.size(), 0);
        check("miso_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
